// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and the 8-channel round-robin arbiter.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    // Requester side: drives requests and release, observes the grant.
    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-channel round-robin arbiter with a registered binary grant index.
// A release always costs one IDLE cycle (gnt_valid=0) before the next grant,
// giving the downstream 3-to-8 decoder a clean gap.
// Optional watchdog: define ARB_TIMEOUT_EN to force-release a grant held
// for TIMEOUT_CYCLES cycles; otherwise grants are held until released.
module rr_arbiter8 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject out-of-range watchdog lengths at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [IDX_W-1:0]   sel_c;
    logic               hit_c;
    logic               rel_c;
    logic               force_c;

    // Rotating priority scan: first set request starting at ptr, wrapping mod 8.
    always_comb begin
        sel_c = ptr_q;
        hit_c = |bus.req;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[ptr_q + IDX_W'(i)]) begin
                sel_c = ptr_q + IDX_W'(i);
            end
        end
    end

    // Normal release: grantee signals done or drops its request.
    assign rel_c = bus.done | ~bus.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
    assign force_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign force_c = 1'b0;
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit_c) state_d = GRANT;
            GRANT:   if (rel_c || force_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and watchdog counter.
    always_comb begin
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit_c) begin
                    gnt_idx_d   = sel_c;
                    gnt_valid_d = 1'b1;
                    ptr_d       = sel_c + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            GRANT: begin
                if (rel_c) begin
                    timeout_d = 1'b0;
                end else if (force_c) begin
                    timeout_d = 1'b1;
                end else begin
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8; honours ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4.
module tb_rr_arbiter8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic valid, input logic [2:0] idx);
        check({tag, ".valid"}, 8'(bus.gnt_valid), 8'(valid));
        check({tag, ".idx"},   8'(bus.gnt_idx),   8'(idx));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 8'(bus.gnt_valid), 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        expect_grant("reset", 1'b0, 3'd0);
        check("reset.timeout", 8'(bus.timeout), 8'd0);

        // Single request, one-cycle latency, then done releases.
        bus.req = 8'b0000_0001;
        tick();
        expect_grant("basic.gnt", 1'b1, 3'd0);
        bus.done = 1'b1;
        tick();
        expect_idle("basic.rel");
        bus.done = 1'b0;
        bus.req  = 8'h00;
        tick();
        expect_idle("basic.idle");

        // Fairness with all requests held: 0..7 then wrap to 0, one gap each.
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_grant($sformatf("fair%0d", k), 1'b1, 3'(k % 8));
            bus.done = 1'b1;
            tick();
            expect_idle($sformatf("fair%0d.gap", k));
            bus.done = 1'b0;
        end
        bus.req = 8'h00;
        tick();

        // Pointer skip: after granting 5, scan 6,7,0,1 misses and 2 wins.
        bus.req = 8'b0010_0000;
        tick();
        expect_grant("skip.g5", 1'b1, 3'd5);
        bus.done = 1'b1;
        tick();
        expect_idle("skip.rel");
        bus.done = 1'b0;
        bus.req  = 8'b0010_0100;
        tick();
        expect_grant("skip.g2", 1'b1, 3'd2);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        tick();

        // Drop release, and other requests do not disturb the grant.
        bus.req = 8'b0000_1000;
        tick();
        expect_grant("drop.g3", 1'b1, 3'd3);
        bus.req = 8'b0001_1000;
        tick();
        expect_grant("drop.hold", 1'b1, 3'd3);
        bus.req = 8'b0001_0000;
        tick();
        expect_grant("drop.rel", 1'b0, 3'd3);
        tick();
        expect_grant("drop.g4", 1'b1, 3'd4);
        bus.done = 1'b1;
        tick();
        expect_idle("drop.rel4");
        bus.done = 1'b0;
        bus.req  = 8'h00;
        tick();

        // Reset in the middle of a grant.
        bus.req = 8'h40;
        tick();
        expect_grant("rstmid.g6", 1'b1, 3'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("rstmid.rst", 1'b0, 3'd0);
        bus.req = 8'hC1;
        tick();
        expect_grant("rstmid.g0", 1'b1, 3'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        tick();

        // Watchdog behaviour on a grant that is never released.
        bus.req = 8'b0000_0100;
        tick();
        expect_grant("wd.g2", 1'b1, 3'd2);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            tick();
            expect_grant($sformatf("wd.hold%0d", c), 1'b1, 3'd2);
            check($sformatf("wd.to%0d", c), 8'(bus.timeout), 8'd0);
        end
        tick();
        expect_idle("wd.force");
        check("wd.pulse", 8'(bus.timeout), 8'd1);
        tick();
        expect_grant("wd.regrant", 1'b1, 3'd2);
        check("wd.pulse_end", 8'(bus.timeout), 8'd0);
        tick();
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        expect_idle("wd.prec");
        check("wd.prec_to", 8'(bus.timeout), 8'd0);
        bus.done = 1'b0;
`else
        for (int c = 2; c <= 7; c++) begin
            tick();
            expect_grant($sformatf("nowd.hold%0d", c), 1'b1, 3'd2);
            check($sformatf("nowd.to%0d", c), 8'(bus.timeout), 8'd0);
        end
        bus.done = 1'b1;
        tick();
        expect_idle("nowd.rel");
        bus.done = 1'b0;
`endif
        bus.req = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
